// File: rtl/spi_module.sv
// Single-byte SPI engine, master or slave, all four CPOL/CPHA modes with selectable bit order.
// Master SCK runs at clk / 2^(DIV+1); slave pins are synchronised and sampled in the clk domain.
module spi_module #(
    parameter int DATA_W  = 8,
    parameter int SYNC_FF = 2
) (
    input  logic              i_sys_clk,
    input  logic              i_sys_rst,
    input  logic [DATA_W-1:0] i_data,
    input  logic [7:0]        i_data_config,
    input  logic              i_trans_en,
    output logic [DATA_W-1:0] o_data,
    output logic              o_interrupt,
    inout  wire               io_SCK,
    inout  wire               io_SS,
    inout  wire               io_MOSI,
    inout  wire               io_MISO
);
    localparam int CW = $clog2(DATA_W + 1);
    localparam int EW = $clog2(2 * DATA_W + 1);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] SETUP = 3'd1;
    localparam logic [2:0] XFER  = 3'd2;
    localparam logic [2:0] HOLD  = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;
    localparam logic [2:0] WAIT  = 3'd5;

    logic [2:0]         state_q, state_d;
    logic [7:0]         cfg_q, cfg_d;
    logic [DATA_W-1:0]  tx_q, tx_d, rx_q, rx_d, data_q, data_d, tx_hold_q, tx_hold_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [EW-1:0]      edge_cnt_q, edge_cnt_d;
    logic [CW-1:0]      bit_cnt_q, bit_cnt_d;
    logic               sck_q, sck_d, drive_q, drive_d, irq_q, irq_d;
    logic               trans_en_q, trans_en_d, hold_vld_q, hold_vld_d;
    logic               ss_prev_q, ss_prev_d, sck_prev_q, sck_prev_d;
    logic [SYNC_FF-1:0] ss_sync_q, ss_sync_d, sck_sync_q, sck_sync_d, mosi_sync_q, mosi_sync_d;

    logic [7:0] cfg, half_m1;
    logic       cpha, cpol, lsb, master, cnt_last, trans_rise;
    logic       ss_s, sck_s, mosi_s, ss_fall, ss_rise, busy_m, out_bit;
    logic       sck_edge, edge_lead, in_bit, do_sample, do_shift;

    always_comb begin
        // NOTE: every _d starts from its _q so no path through this block can infer a latch.
        state_d    = state_q;
        cfg_d      = cfg_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        data_d     = data_q;
        tx_hold_d  = tx_hold_q;
        hold_vld_d = hold_vld_q;
        cnt_d      = cnt_q;
        edge_cnt_d = edge_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        sck_d      = sck_q;
        drive_d    = drive_q;
        irq_d      = irq_q;

        // Mode and timing come straight from the config port only while idle.
        cfg      = (state_q == IDLE) ? i_data_config : cfg_q;
        cpha     = cfg[0];
        cpol     = cfg[1];
        lsb      = cfg[2];
        master   = cfg[3];
        half_m1  = (8'd1 << cfg[6:4]) - 8'd1;
        cnt_last = (cnt_q == half_m1);

        ss_sync_d   = {ss_sync_q[SYNC_FF-2:0], io_SS};
        sck_sync_d  = {sck_sync_q[SYNC_FF-2:0], io_SCK};
        mosi_sync_d = {mosi_sync_q[SYNC_FF-2:0], io_MOSI};
        ss_s        = ss_sync_q[SYNC_FF-1];
        sck_s       = sck_sync_q[SYNC_FF-1];
        mosi_s      = mosi_sync_q[SYNC_FF-1];
        ss_prev_d   = ss_s;
        sck_prev_d  = sck_s;
        ss_fall     = ss_prev_q & ~ss_s;
        ss_rise     = ~ss_prev_q & ss_s;
        trans_en_d  = i_trans_en;
        trans_rise  = i_trans_en & ~trans_en_q;

        busy_m   = (state_q == SETUP) || (state_q == XFER) || (state_q == HOLD);
        out_bit  = lsb ? tx_q[0] : tx_q[DATA_W-1];
        sck_edge = 1'b0;
        edge_lead = 1'b0;
        in_bit   = 1'b0;

        if (!master && trans_rise) begin
            tx_hold_d  = i_data;
            hold_vld_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (master && trans_rise) begin
                    cfg_d   = i_data_config;
                    tx_d    = i_data;
                    sck_d   = cpol;
                    state_d = SETUP;
                end else if (!master && ss_fall) begin
                    cfg_d   = i_data_config;
                    tx_d    = hold_vld_q ? tx_hold_q : i_data;
                    state_d = XFER;
                end
                if ((master && trans_rise) || (!master && ss_fall)) begin
                    rx_d       = '0;
                    irq_d      = 1'b0;
                    drive_d    = ~cpha;
                    cnt_d      = '0;
                    edge_cnt_d = '0;
                    bit_cnt_d  = '0;
                end
            end
            SETUP, HOLD: begin
                cnt_d = cnt_last ? 8'd0 : cnt_q + 8'd1;
                if (cnt_last) state_d = (state_q == SETUP) ? XFER : DONE;
            end
            XFER: begin
                if (master) begin
                    cnt_d = cnt_last ? 8'd0 : cnt_q + 8'd1;
                    if (cnt_last) begin
                        sck_edge   = 1'b1;
                        edge_lead  = (sck_q == cpol);
                        in_bit     = io_MISO;
                        sck_d      = ~sck_q;
                        edge_cnt_d = edge_cnt_q + 1'b1;
                        if (edge_cnt_q == EW'(2 * DATA_W - 1)) state_d = HOLD;
                    end
                end else if (ss_rise) begin
                    // Frame cut short: drop it without touching o_data or the interrupt.
                    state_d = IDLE;
                    drive_d = 1'b0;
                end else if (sck_s != sck_prev_q) begin
                    sck_edge  = 1'b1;
                    edge_lead = (sck_prev_q == cpol);
                    in_bit    = mosi_s;
                end
            end
            DONE: begin
                data_d  = rx_q;
                irq_d   = cfg[7];
                state_d = master ? IDLE : WAIT;
            end
            WAIT: begin
                if (ss_s) begin
                    state_d = IDLE;
                    drive_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        // Sample on leading edge when CPHA=0, on trailing edge when CPHA=1; shift on the other.
        do_sample = sck_edge & (edge_lead ^ cpha);
        do_shift  = sck_edge & ~(edge_lead ^ cpha);
        if (do_sample && (bit_cnt_q < CW'(DATA_W))) begin
            rx_d      = lsb ? {in_bit, rx_q[DATA_W-1:1]} : {rx_q[DATA_W-2:0], in_bit};
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (!master && (bit_cnt_q == CW'(DATA_W - 1))) state_d = DONE;
        end
        // With CPHA=1 the first shift edge only exposes the already-loaded first bit.
        if (do_shift) begin
            if (drive_q) tx_d = lsb ? {1'b0, tx_q[DATA_W-1:1]} : {tx_q[DATA_W-2:0], 1'b0};
            else         drive_d = 1'b1;
        end
    end

    always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!i_sys_rst) begin
            state_q     <= IDLE;
            cfg_q       <= '0;
            tx_q        <= '0;
            rx_q        <= '0;
            data_q      <= '0;
            tx_hold_q   <= '0;
            hold_vld_q  <= 1'b0;
            cnt_q       <= '0;
            edge_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            sck_q       <= 1'b0;
            drive_q     <= 1'b0;
            irq_q       <= 1'b0;
            trans_en_q  <= 1'b0;
            ss_prev_q   <= 1'b1;
            sck_prev_q  <= 1'b0;
            ss_sync_q   <= '1;
            sck_sync_q  <= '0;
            mosi_sync_q <= '0;
        end else begin
            state_q     <= state_d;
            cfg_q       <= cfg_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            data_q      <= data_d;
            tx_hold_q   <= tx_hold_d;
            hold_vld_q  <= hold_vld_d;
            cnt_q       <= cnt_d;
            edge_cnt_q  <= edge_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            sck_q       <= sck_d;
            drive_q     <= drive_d;
            irq_q       <= irq_d;
            trans_en_q  <= trans_en_d;
            ss_prev_q   <= ss_prev_d;
            sck_prev_q  <= sck_prev_d;
            ss_sync_q   <= ss_sync_d;
            sck_sync_q  <= sck_sync_d;
            mosi_sync_q <= mosi_sync_d;
        end
    end

    assign o_data      = data_q;
    assign o_interrupt = irq_q;

    assign io_SCK  = master ? ((state_q == IDLE) ? cpol : sck_q) : 1'bz;
    assign io_SS   = master ? ~busy_m : 1'bz;
    assign io_MOSI = master ? (busy_m & drive_q & out_bit) : 1'bz;
    assign io_MISO = (!master && (io_SS == 1'b0)) ? ((state_q != IDLE) & drive_q & out_bit) : 1'bz;
endmodule

// File: tb/tb_spi_module.sv
// Self-checking bench for spi_module: directed and randomised master/slave transfers
// against a bit-order/byte-level reference model.
module tb_spi_module;
    logic       i_sys_clk = 1'b0;
    logic       i_sys_rst, i_trans_en, o_interrupt;
    logic [7:0] i_data, i_data_config, o_data;
    wire        io_SCK, io_SS, io_MOSI, io_MISO;

    logic tb_drv, tb_sck, tb_ss, tb_mosi, tb_miso, loop_sel;
    int   total = 0;
    int   bad   = 0;
    logic       armed, model_irq;
    logic [7:0] armed_byte, model_odata;

    assign io_SCK  = tb_drv ? tb_sck  : 1'bz;
    assign io_SS   = tb_drv ? tb_ss   : 1'bz;
    assign io_MOSI = tb_drv ? tb_mosi : 1'bz;
    assign io_MISO = tb_drv ? 1'bz : (loop_sel ? io_MOSI : tb_miso);

    always #5 i_sys_clk = ~i_sys_clk;

    spi_module #(.DATA_W(8), .SYNC_FF(2)) dut (
        .i_sys_clk    (i_sys_clk),
        .i_sys_rst    (i_sys_rst),
        .i_data       (i_data),
        .i_data_config(i_data_config),
        .i_trans_en   (i_trans_en),
        .o_data       (o_data),
        .o_interrupt  (o_interrupt),
        .io_SCK       (io_SCK),
        .io_SS        (io_SS),
        .io_MOSI      (io_MOSI),
        .io_MISO      (io_MISO)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // i-th bit on the wire for byte b in the selected order
    function automatic logic nth_bit(input logic [7:0] b, input int i, input logic lsb);
        return lsb ? b[i] : b[7-i];
    endfunction

    function automatic logic [7:0] wire_seq(input logic [7:0] b, input logic lsb);
        logic [7:0] s;
        for (int i = 0; i < 8; i++) s[i] = nth_bit(b, i, lsb);
        return s;
    endfunction

    // Bench acts as slave; loop=1 wires MISO back from MOSI, poke toggles i_trans_en mid-frame.
    task automatic master_xfer(input logic [7:0] cfg, input logic [7:0] tx, input logic [7:0] ext,
                               input logic loop, input logic poke, input string tag);
        logic cpha, cpol, lsb, prev, lead, seen_low, done, poked;
        int   h, leads, samples, lead_cyc0, lead_cyc1, idx;
        logic [7:0] got, exp_rx;
        cpha = cfg[0]; cpol = cfg[1]; lsb = cfg[2];
        h = 1 << cfg[6:4];
        exp_rx = loop ? tx : ext;
        tb_drv = 1'b0; loop_sel = loop; i_data_config = cfg; i_data = tx;
        tb_miso = nth_bit(ext, 0, lsb);
        @(negedge i_sys_clk);
        check({tag, "_idle_sck"}, io_SCK, cpol);
        i_trans_en = 1'b1;
        @(negedge i_sys_clk);
        i_trans_en = 1'b0;
        prev = cpol; leads = 0; samples = 0; seen_low = 0; done = 0; poked = 0;
        got = '0; lead_cyc0 = 0; lead_cyc1 = 0;
        for (int cyc = 0; cyc < 64 * h + 64 && !done; cyc++) begin
            @(negedge i_sys_clk);
            i_trans_en = 1'b0;
            if (io_SS === 1'b0) seen_low = 1'b1;
            else if (seen_low) done = 1'b1;
            if (io_SCK !== prev) begin
                lead = (prev === cpol);
                prev = io_SCK;
                if (lead) begin
                    if (leads == 0) lead_cyc0 = cyc;
                    if (leads == 1) lead_cyc1 = cyc;
                    leads++;
                end
                if (lead ^ cpha) begin
                    if (samples < 8) got[samples] = io_MOSI;
                    samples++;
                end else begin
                    idx = cpha ? leads - 1 : leads;
                    if (idx < 8) tb_miso = nth_bit(ext, idx, lsb);
                end
            end
            if (poke && leads == 3 && !poked) begin
                i_trans_en = 1'b1;
                poked = 1'b1;
            end
        end
        i_trans_en = 1'b0;
        check({tag, "_ss_release"}, done, 1'b1);
        check({tag, "_sck_pulses"}, leads, 8);
        check({tag, "_mosi_seq"}, got, wire_seq(tx, lsb));
        check({tag, "_sck_period"}, lead_cyc1 - lead_cyc0, 2 * h);
        repeat (2) @(negedge i_sys_clk);
        check({tag, "_o_data"}, o_data, exp_rx);
        check({tag, "_irq"}, o_interrupt, cfg[7]);
        check({tag, "_ss_idle"}, io_SS, 1'b1);
        check({tag, "_sck_idle"}, io_SCK, cpol);
        model_odata = exp_rx;
        model_irq = cfg[7];
    endtask

    task automatic arm_slave(input logic [7:0] cfg, input logic [7:0] b);
        tb_drv = 1'b1; tb_ss = 1'b1; tb_sck = cfg[1]; i_data_config = cfg; i_data = b;
        @(negedge i_sys_clk);
        i_trans_en = 1'b1;
        @(negedge i_sys_clk);
        i_trans_en = 1'b0;
        armed = 1'b1;
        armed_byte = b;
    endtask

    // Bench acts as master at SCK = clk/16; nbits<8 aborts the frame, extra adds pulses after it.
    task automatic slave_xfer(input logic [7:0] cfg, input logic [7:0] mbyte, input logic [7:0] din,
                              input int nbits, input int extra, input string tag);
        logic cpha, cpol, lsb;
        logic [7:0] got, exp_tx;
        cpha = cfg[0]; cpol = cfg[1]; lsb = cfg[2];
        exp_tx = armed ? armed_byte : din;
        got = '0;
        tb_sck = cpol; tb_ss = 1'b1; tb_mosi = 1'b0; tb_drv = 1'b1;
        i_data_config = cfg; i_data = din;
        repeat (8) @(negedge i_sys_clk);
        tb_ss = 1'b0;
        repeat (8) @(negedge i_sys_clk);
        for (int i = 0; i < nbits + extra; i++) begin
            if (!cpha) begin
                tb_mosi = (i < 8) ? nth_bit(mbyte, i, lsb) : 1'($urandom_range(0, 1));
                repeat (8) @(negedge i_sys_clk);
                tb_sck = ~cpol;
                if (i < 8) got[i] = io_MISO;
                repeat (8) @(negedge i_sys_clk);
                tb_sck = cpol;
            end else begin
                tb_sck = ~cpol;
                tb_mosi = (i < 8) ? nth_bit(mbyte, i, lsb) : 1'($urandom_range(0, 1));
                repeat (8) @(negedge i_sys_clk);
                tb_sck = cpol;
                if (i < 8) got[i] = io_MISO;
                repeat (8) @(negedge i_sys_clk);
            end
        end
        repeat (8) @(negedge i_sys_clk);
        tb_ss = 1'b1;
        repeat (8) @(negedge i_sys_clk);
        if (nbits == 8) begin
            check({tag, "_miso_seq"}, got, wire_seq(exp_tx, lsb));
            model_odata = mbyte;
            model_irq = cfg[7];
        end else begin
            model_irq = 1'b0;
        end
        check({tag, "_o_data"}, o_data, model_odata);
        check({tag, "_irq"}, o_interrupt, model_irq);
    endtask

    initial begin
        logic [7:0] c, a, b;
        int ss_low;
        i_sys_rst = 1'b0; i_data_config = 8'h88; i_data = 8'h00; i_trans_en = 1'b0;
        tb_drv = 1'b0; tb_sck = 1'b0; tb_ss = 1'b1; tb_mosi = 1'b0; tb_miso = 1'b0; loop_sel = 1'b0;
        armed = 1'b0; armed_byte = 8'h00; model_odata = 8'h00; model_irq = 1'b0;
        repeat (3) @(negedge i_sys_clk);
        check("rst_o_data", o_data, 8'h00);
        check("rst_irq", o_interrupt, 1'b0);
        check("rst_ss", io_SS, 1'b1);
        check("rst_sck", io_SCK, 1'b0);
        check("rst_mosi", io_MOSI, 1'b0);
        i_sys_rst = 1'b1;
        repeat (2) @(negedge i_sys_clk);

        master_xfer(8'h88, 8'hA5, 8'h00, 1'b1, 1'b0, "m_mode0_loop");
        master_xfer(8'h8F, 8'h3C, 8'hC3, 1'b0, 1'b0, "m_mode3_lsb");

        master_xfer(8'hB8, 8'($urandom), 8'($urandom), 1'b0, 1'b1, "m_div3_poke");
        ss_low = 0;
        repeat (40) begin
            @(negedge i_sys_clk);
            if (io_SS === 1'b0) ss_low++;
        end
        check("m_div3_no_restart", ss_low, 0);

        for (int k = 0; k < 4; k++) begin
            c = {1'($urandom_range(0, 1)), 3'($urandom_range(0, 2)), 1'b1, 3'($urandom_range(0, 7))};
            master_xfer(c, 8'($urandom), 8'($urandom), 1'b0, 1'b0, "m_rand");
        end

        slave_xfer(8'h80, 8'h81, 8'h5A, 8, 0, "s_msb");
        slave_xfer(8'h84, 8'h81, 8'h5A, 8, 0, "s_lsb");
        slave_xfer(8'h83, 8'($urandom), 8'($urandom), 8, 2, "s_mode3_extra");

        a = 8'($urandom);
        b = ~a;
        arm_slave(8'h81, a);
        slave_xfer(8'h81, 8'($urandom), b, 8, 0, "s_armed");
        slave_xfer(8'h86, 8'($urandom), b, 8, 1, "s_mode2_lsb");

        slave_xfer(8'h04, 8'($urandom) | 8'h01, 8'h00, 8, 0, "s_noirq");
        slave_xfer(8'h80, 8'($urandom), 8'h00, 4, 0, "s_abort");
        slave_xfer(8'h80, 8'($urandom) | 8'h10, 8'h00, 8, 0, "s_after_abort");

        tb_drv = 1'b0; loop_sel = 1'b1; i_data_config = 8'hAB; i_data = 8'h96;
        @(negedge i_sys_clk);
        i_trans_en = 1'b1;
        @(negedge i_sys_clk);
        i_trans_en = 1'b0;
        repeat (20) @(negedge i_sys_clk);
        check("rst_mid_busy", io_SS, 1'b0);
        i_sys_rst = 1'b0;
        #1;
        check("rst_mid_o_data", o_data, 8'h00);
        check("rst_mid_irq", o_interrupt, 1'b0);
        check("rst_mid_ss", io_SS, 1'b1);
        check("rst_mid_sck", io_SCK, 1'b1);
        repeat (2) @(negedge i_sys_clk);
        i_sys_rst = 1'b1;
        repeat (2) @(negedge i_sys_clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
